board_sequencer: RTL
====================

BOARD_SEQUENCER -- requirements
Module: board_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; clk and reset are the only timing/init ports.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  async active-high reset.
REQ-004 start  input  1  one-cycle pulse; clears board and begins new game.
REQ-005 move_valid  input  1  move request qualifier.
REQ-006 move_macro  input  4  macro board of requested move, legal 1..9.
REQ-007 move_micro  input  4  cell within macro board, legal 1..9.
REQ-008 move_ready  output  1  high only in WAIT_MOVE; a move is accepted on an edge where move_valid=1 and move_ready=1.
REQ-009 ram_we, ram_data[1:0], ram_addr_macro[3:0], ram_addr_micro[3:0]  outputs  board RAM write enable, cell data, addresses.
REQ-010 ram_q  input  2  board RAM cell read data, valid one cycle after address.
REQ-011 ram_state  input  2  addressed macro board result: 00 open, 01 P1 won, 10 P2 won, 11 draw.
REQ-012 player  output  1  side to move: 0=P1 (cell 01), 1=P2 (cell 10).
REQ-013 next_macro  output  4  forced macro board; 0 = free choice.
REQ-014 move_done, move_err  output  1 each  one-cycle result pulses; err_code  output  2  valid with move_err.
REQ-015 game_state  output  2  overall result, same encoding as ram_state.

Function
REQ-016 States: IDLE, CLEAR, WAIT_MOVE, READ, CHECK, WRITE, SETTLE, UPDATE, OVER.
REQ-017 IDLE/OVER: ram_we=0, addresses 0, move_ready=0; leave only on start.
REQ-018 start in any state -> CLEAR next cycle, aborting any move in flight; player=0, next_macro=0, all nine macro statuses=00, game_state=00.
REQ-019 CLEAR: 81 consecutive cycles, ram_we=1, ram_data=00, addresses macro 1..9 outer, micro 1..9 inner (1/1 first, 9/9 last); then WAIT_MOVE.
REQ-020 Acceptance latches macro/micro, -> READ: addresses driven, ram_we=0.
REQ-021 CHECK samples ram_q; priority: macro or micro outside 1..9 -> err 01; next_macro!=0 and macro!=next_macro, or status[macro]!=00 -> err 10; ram_q!=00 -> err 11.
REQ-022 Error: move_err=1 and err_code for one cycle in CHECK cycle, return to WAIT_MOVE; player, next_macro, RAM unchanged.
REQ-023 Legal: WRITE one cycle, ram_we=1, ram_data=player?10:01; SETTLE one cycle, addresses held, ram_we=0.
REQ-024 UPDATE: status[macro]<=ram_state; player toggles; next_macro<=micro if updated status[micro]==00 else 0; move_done=1 this cycle.
REQ-025 Latency: accept edge k -> move_done high in cycle between edges k+4 and k+5; move_ready low from k to UPDATE exit.
REQ-026 game_state from statuses: any row/column/diagonal of three equal 01 or 10 -> that value; else all nine nonzero -> 11; else 00.
REQ-027 After UPDATE: game_state!=00 -> OVER, else WAIT_MOVE.
REQ-028 Addresses and ram_data are 0 in every state except CLEAR, READ, CHECK, WRITE, SETTLE.

Reset
REQ-029 reset asserted: immediately IDLE, all outputs 0, statuses 00, player 0, next_macro 0; RAM contents not touched.
REQ-030 reset mid-CLEAR or mid-move: write sequence abandoned, ram_we low without waiting for clk.

Verification
REQ-031 reset, start -> 81 writes of 00 covering 1/1..9/9, then move_ready=1, player=0, next_macro=0.
REQ-032 Move 2/1 -> WRITE of 01 at 2/1, move_done 5 edges after acceptance, player=1, next_macro=1.
REQ-033 Next move 3/5 while next_macro=1 -> move_err, err_code=10, player stays 1; then 1/2 -> accepted, data 10.
REQ-034 Repeat occupied cell (ram_q=01) -> err_code=11; move 0/4 -> err_code=01.
REQ-035 Model RAM: P1 wins macros 1,5,9 -> game_state=01 after third win, state OVER, move_ready=0; macro 2 finished draw (11) then micro 2 sent -> next_macro=0.
REQ-036 start pulsed during SETTLE -> no move_done, CLEAR restarts at 1/1; reset during CLEAR -> ram_we=0 asynchronously.

Source files
------------

// File: rtl/board_sequencer.sv
// rtl/board_sequencer.sv - ultimate tic-tac-toe move sequencer over an external board RAM
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   start                 clear the board and begin a new game
//   move_valid/move_ready move handshake; move_macro/move_micro select board and cell (1..9)
//   ram_we, ram_data      board RAM write enable and cell data (01 = P1, 10 = P2)
//   ram_addr_macro/micro  board RAM address, shared by reads and writes
//   ram_q                 cell read data, one cycle after the address
//   ram_state             result of the addressed macro board (00 open, 01 P1, 10 P2, 11 draw)
//   player                side to move (0 = P1, 1 = P2)
//   next_macro            macro board the next move must use, 0 = free choice
//   move_done, move_err   one-cycle result pulses; err_code qualifies move_err
//   game_state            overall result, same encoding as ram_state

module board_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       move_valid,
  input  logic [3:0] move_macro,
  input  logic [3:0] move_micro,
  output logic       move_ready,
  output logic       ram_we,
  output logic [1:0] ram_data,
  output logic [3:0] ram_addr_macro,
  output logic [3:0] ram_addr_micro,
  input  logic [1:0] ram_q,
  input  logic [1:0] ram_state,
  output logic       player,
  output logic [3:0] next_macro,
  output logic       move_done,
  output logic       move_err,
  output logic [1:0] err_code,
  output logic [1:0] game_state
);

  typedef enum logic [3:0] {
    IDLE, CLEAR, WAIT_MOVE, READ, CHECK, WRITE, SETTLE, UPDATE, OVER
  } state_t;

  state_t     state;
  logic [3:0] mv_macro;
  logic [3:0] mv_micro;
  logic [1:0] status [1:9];

  logic [1:0] macro_status;
  logic [1:0] micro_status;
  logic [1:0] micro_upd;
  logic       range_bad;
  logic [1:0] chk_code;
  logic [1:0] lines [0:7];
  logic       all_set;

  function automatic logic [1:0] line_win(input logic [1:0] a, input logic [1:0] b,
                                          input logic [1:0] c);
    line_win = 2'b00;
    if (a != 2'b00 && a != 2'b11 && a == b && b == c) line_win = a;
  endfunction

  // Status of the latched macro board and of the board the move points at.
  always_comb begin
    macro_status = 2'b00;
    micro_status = 2'b00;
    for (int i = 1; i <= 9; i++) begin
      if (mv_macro == 4'(i)) macro_status = status[i];
      if (mv_micro == 4'(i)) micro_status = status[i];
    end
  end

  // When a move points back into its own board, the freshly reported result
  // decides whether that board is still open.
  assign micro_upd = (mv_micro == mv_macro) ? ram_state : micro_status;

  assign range_bad = (mv_macro == 4'd0) || (mv_macro > 4'd9) ||
                     (mv_micro == 4'd0) || (mv_micro > 4'd9);

  always_comb begin
    chk_code = 2'b00;
    if (range_bad)
      chk_code = 2'b01;
    else if ((next_macro != 4'd0 && mv_macro != next_macro) || macro_status != 2'b00)
      chk_code = 2'b10;
    else if (ram_q != 2'b00)
      chk_code = 2'b11;
  end

  // The occupancy check needs ram_q, which only arrives in the CHECK cycle,
  // so the error pulse is decoded here rather than registered.
  assign move_err = (state == CHECK) && (chk_code != 2'b00);
  assign err_code = move_err ? chk_code : 2'b00;

  always_comb begin
    lines[0] = line_win(status[1], status[2], status[3]);
    lines[1] = line_win(status[4], status[5], status[6]);
    lines[2] = line_win(status[7], status[8], status[9]);
    lines[3] = line_win(status[1], status[4], status[7]);
    lines[4] = line_win(status[2], status[5], status[8]);
    lines[5] = line_win(status[3], status[6], status[9]);
    lines[6] = line_win(status[1], status[5], status[9]);
    lines[7] = line_win(status[3], status[5], status[7]);
    all_set = 1'b1;
    for (int i = 1; i <= 9; i++)
      if (status[i] == 2'b00) all_set = 1'b0;
    game_state = all_set ? 2'b11 : 2'b00;
    for (int l = 7; l >= 0; l--)
      if (lines[l] != 2'b00) game_state = lines[l];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      mv_macro       <= 4'd0;
      mv_micro       <= 4'd0;
      move_ready     <= 1'b0;
      ram_we         <= 1'b0;
      ram_data       <= 2'b00;
      ram_addr_macro <= 4'd0;
      ram_addr_micro <= 4'd0;
      player         <= 1'b0;
      next_macro     <= 4'd0;
      move_done      <= 1'b0;
      for (int i = 1; i <= 9; i++) status[i] <= 2'b00;
    end else if (start) begin
      // A new game wins over anything in flight, including a pending write.
      state          <= CLEAR;
      move_ready     <= 1'b0;
      ram_we         <= 1'b1;
      ram_data       <= 2'b00;
      ram_addr_macro <= 4'd1;
      ram_addr_micro <= 4'd1;
      player         <= 1'b0;
      next_macro     <= 4'd0;
      move_done      <= 1'b0;
      for (int i = 1; i <= 9; i++) status[i] <= 2'b00;
    end else begin
      case (state)
        CLEAR: begin
          // The address registers double as the clear counter.
          if (ram_addr_micro == 4'd9) begin
            if (ram_addr_macro == 4'd9) begin
              state          <= WAIT_MOVE;
              ram_we         <= 1'b0;
              ram_addr_macro <= 4'd0;
              ram_addr_micro <= 4'd0;
              move_ready     <= 1'b1;
            end else begin
              ram_addr_macro <= ram_addr_macro + 4'd1;
              ram_addr_micro <= 4'd1;
            end
          end else begin
            ram_addr_micro <= ram_addr_micro + 4'd1;
          end
        end
        WAIT_MOVE: begin
          if (move_valid) begin
            mv_macro       <= move_macro;
            mv_micro       <= move_micro;
            ram_addr_macro <= move_macro;
            ram_addr_micro <= move_micro;
            move_ready     <= 1'b0;
            state          <= READ;
          end
        end
        READ: state <= CHECK;
        CHECK: begin
          if (chk_code != 2'b00) begin
            state          <= WAIT_MOVE;
            ram_addr_macro <= 4'd0;
            ram_addr_micro <= 4'd0;
            move_ready     <= 1'b1;
          end else begin
            state    <= WRITE;
            ram_we   <= 1'b1;
            ram_data <= player ? 2'b10 : 2'b01;
          end
        end
        WRITE: begin
          state    <= SETTLE;
          ram_we   <= 1'b0;
          ram_data <= 2'b00;
        end
        SETTLE: begin
          // ram_state reflects the just-written cell while the address is held.
          state          <= UPDATE;
          ram_addr_macro <= 4'd0;
          ram_addr_micro <= 4'd0;
          for (int i = 1; i <= 9; i++)
            if (mv_macro == 4'(i)) status[i] <= ram_state;
          player     <= ~player;
          next_macro <= (micro_upd == 2'b00) ? mv_micro : 4'd0;
          move_done  <= 1'b1;
        end
        UPDATE: begin
          move_done <= 1'b0;
          if (game_state != 2'b00) begin
            state <= OVER;
          end else begin
            state      <= WAIT_MOVE;
            move_ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
